calc_operand_ctrl: RTL and testbench
====================================

CALC_OPERAND_CTRL -- requirements
Module: calc_operand_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_CYCLES, default 100000000, giving clock cycles per countdown second.
REQ-002 The block SHALL have parameter ERR_SECS, default 5, giving the error countdown start value (1..15).
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port current_state, input, 4, the central FSM state code (7 SELECT_OP, 8 SELECT_MAT, 9 CHECK, 12 ERROR).
REQ-006 The block SHALL have port btn_c, input, 1, a debounced single-cycle confirm pulse.
REQ-007 The block SHALL have port sw, input, 8, switches: [1:0] op code in SELECT_OP, [3:0] matrix ID in SELECT_MAT/ERROR.
REQ-008 The block SHALL have port dim_req, output, 1, a one-cycle dimension lookup request to matrix storage.
REQ-009 The block SHALL have port dim_id, output, 4, the ID being looked up, held until dim_valid.
REQ-010 The block SHALL have ports dim_valid (input, 1), dim_m (input, 3) and dim_n (input, 3): the lookup response; m=0 means slot empty.
REQ-011 The block SHALL have outputs calc_mat_conf, check_valid, check_invalid and error_timeout, each 1 bit, single-cycle pulses to the central FSM.
REQ-012 The block SHALL have outputs op_type (2), id_a (4) and id_b (4): the latched operation and operands.
REQ-013 The block SHALL have outputs res_m (3), res_n (3) and countdown (4): result dimensions and seconds remaining.

Function
REQ-014 Op codes SHALL be: 00 add, 01 scalar-multiply, 10 transpose, 11 matrix-multiply; 01/10 are unary, 00/11 binary.
REQ-015 In state 7, btn_c SHALL latch op_type<=sw[1:0] on that edge.
REQ-016 In state 8 or 12, the first btn_c SHALL latch id_a<=sw[3:0]; for unary ops calc_mat_conf SHALL pulse the next cycle.
REQ-017 For binary ops, a second btn_c in state 8 or 12 SHALL latch id_b<=sw[3:0], then calc_mat_conf SHALL pulse the next cycle.
REQ-018 After calc_mat_conf, the operand-entry phase SHALL reset so the next entry starts again at A.
REQ-019 On entry to state 9 the block SHALL pulse dim_req with dim_id=id_a and wait for dim_valid; for binary ops it SHALL then request id_b.
REQ-020 A dim_valid asserted in the same cycle as dim_req SHALL be ignored; a response is accepted only from the cycle after the request.
REQ-021 One cycle after the final dim_valid, exactly one of check_valid or check_invalid SHALL pulse.
REQ-022 The validity rules SHALL be: any operand with m=0 is invalid; add needs mA=mB and nA=nB; matrix-multiply needs nA=mB; unary ops need only a non-empty A.
REQ-023 On a valid result, res_m/res_n SHALL be: add/scalar (mA,nA); transpose (nA,mA); matrix-multiply (mA,nB). They are unchanged on invalid.
REQ-024 On entry to state 12, countdown SHALL load ERR_SECS and a tick counter SHALL clear to 0.
REQ-025 The tick counter SHALL wrap at TICK_CYCLES-1 and decrement countdown on wrap.
REQ-026 When countdown reaches 0, error_timeout SHALL pulse once and countdown SHALL hold at 0.
REQ-027 A calc_mat_conf in state 12 SHALL suppress error_timeout in that cycle and stop the countdown; conf wins over a simultaneous timeout.
REQ-028 When current_state is outside 7..12, all internal phases SHALL return to idle, pulses SHALL be 0, and latched IDs/op SHALL hold.
REQ-029 A btn_c in state 9 SHALL be ignored.

Reset
REQ-030 On rst_n=0 the block SHALL immediately clear all outputs and registers to 0, including dim_req, the pulses, op_type, id_a, id_b, res_m, res_n, countdown and the tick counter.
REQ-031 Reset mid-lookup or mid-countdown SHALL abandon the operation; a late dim_valid after reset SHALL be ignored.

Verification
REQ-032 Test add with TICK_CYCLES=4: op 00; A=1 (2x3), B=2 (2x3) -> one calc_mat_conf, dim_req twice, check_valid, res=(2,3).
REQ-033 Test matrix-multiply: A=1 (2x3), B=3 (3x4) -> check_valid, res=(2,4); B=4 (2x2) -> check_invalid, res unchanged.
REQ-034 Test transpose of A=5 (3x1) -> a single dim_req, check_valid, res=(1,3); A empty (m=0) -> check_invalid.
REQ-035 Test error countdown with ERR_SECS=3, TICK_CYCLES=4: countdown 3->2->1->0 at 4-cycle spacing, error_timeout exactly once, 12 cycles after entry.
REQ-036 Test retry in state 12: re-enter valid IDs before timeout -> calc_mat_conf pulses, no error_timeout; conf coincident with timeout -> only calc_mat_conf.
REQ-037 Test rst_n low while waiting for dim_valid -> all outputs 0 at once; a dim_valid after release produces no check pulse.

Source files
------------

// File: rtl/calc_operand_ctrl.sv
// Operand entry, dimension lookup/compatibility check and error-state countdown
// for the matrix calculator's central FSM.
module calc_operand_ctrl #(
  parameter int TICK_CYCLES = 100000000,
  parameter int ERR_SECS    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] current_state,
  input  logic       btn_c,
  input  logic [7:0] sw,
  output logic       dim_req,
  output logic [3:0] dim_id,
  input  logic       dim_valid,
  input  logic [2:0] dim_m,
  input  logic [2:0] dim_n,
  output logic       calc_mat_conf,
  output logic       check_valid,
  output logic       check_invalid,
  output logic       error_timeout,
  output logic [1:0] op_type,
  output logic [3:0] id_a,
  output logic [3:0] id_b,
  output logic [2:0] res_m,
  output logic [2:0] res_n,
  output logic [3:0] countdown
);

  localparam logic [3:0] ST_SELECT_OP  = 4'd7;
  localparam logic [3:0] ST_SELECT_MAT = 4'd8;
  localparam logic [3:0] ST_CHECK      = 4'd9;
  localparam logic [3:0] ST_ERROR      = 4'd12;

  localparam logic [1:0] LK_IDLE   = 2'd0;
  localparam logic [1:0] LK_WAIT_A = 2'd1;
  localparam logic [1:0] LK_WAIT_B = 2'd2;
  localparam logic [1:0] LK_DONE   = 2'd3;

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_TRN = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  function automatic logic check_fit(input logic [1:0] op,
                                     input logic [2:0] am, input logic [2:0] an,
                                     input logic [2:0] bm, input logic [2:0] bn);
    logic fit;
    case (op)
      OP_ADD:  fit = (am != 3'd0) && (bm != 3'd0) && (am == bm) && (an == bn);
      OP_MUL:  fit = (am != 3'd0) && (bm != 3'd0) && (an == bm);
      default: fit = (am != 3'd0);
    endcase
    return fit;
  endfunction

  function automatic logic [5:0] result_dims(input logic [1:0] op,
                                             input logic [2:0] am, input logic [2:0] an,
                                             input logic [2:0] bn);
    logic [5:0] dims;
    case (op)
      OP_TRN:  dims = {an, am};
      OP_MUL:  dims = {am, bn};
      default: dims = {am, an};
    endcase
    return dims;
  endfunction

  logic [3:0]        prev_state;
  logic              entry_b;
  logic [1:0]        lk_phase;
  logic [2:0]        a_m, a_n;
  logic [TICK_W-1:0] tick;
  logic              cd_run;

  logic       in_range, in_mat, is_unary, conf_now;
  logic       enter_check, enter_err, resp_ok, tick_wrap;
  logic [2:0] fin_am, fin_an;
  logic       fin_fit;
  logic [5:0] fin_dims;
  logic       unused_sw;

  assign unused_sw = ^sw[7:4];

  always_comb begin
    in_range    = (current_state >= ST_SELECT_OP) && (current_state <= ST_ERROR);
    in_mat      = (current_state == ST_SELECT_MAT) || (current_state == ST_ERROR);
    is_unary    = op_type[1] ^ op_type[0];
    conf_now    = in_mat && btn_c && (entry_b || is_unary);
    enter_check = (current_state == ST_CHECK) && (prev_state != ST_CHECK);
    enter_err   = (current_state == ST_ERROR) && (prev_state != ST_ERROR);
    // a response in the same cycle as the request belongs to nobody
    resp_ok     = dim_valid && !dim_req;
    tick_wrap   = (tick == TICK_LAST);
    fin_am      = (lk_phase == LK_WAIT_B) ? a_m : dim_m;
    fin_an      = (lk_phase == LK_WAIT_B) ? a_n : dim_n;
    fin_fit     = check_fit(op_type, fin_am, fin_an, dim_m, dim_n);
    fin_dims    = result_dims(op_type, fin_am, fin_an, dim_n);
  end

  // Operation and operand entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_state    <= 4'd0;
      op_type       <= 2'd0;
      id_a          <= 4'd0;
      id_b          <= 4'd0;
      entry_b       <= 1'b0;
      calc_mat_conf <= 1'b0;
    end else begin
      prev_state    <= current_state;
      calc_mat_conf <= conf_now;
      if (!in_range) begin
        entry_b <= 1'b0;
      end else begin
        if ((current_state == ST_SELECT_OP) && btn_c)
          op_type <= sw[1:0];
        if (in_mat && btn_c) begin
          if (!entry_b) begin
            id_a    <= sw[3:0];
            entry_b <= !is_unary;
          end else begin
            id_b    <= sw[3:0];
            entry_b <= 1'b0;
          end
        end
      end
    end
  end

  // Dimension lookup and compatibility check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_phase      <= LK_IDLE;
      dim_req       <= 1'b0;
      dim_id        <= 4'd0;
      a_m           <= 3'd0;
      a_n           <= 3'd0;
      check_valid   <= 1'b0;
      check_invalid <= 1'b0;
      res_m         <= 3'd0;
      res_n         <= 3'd0;
    end else begin
      dim_req       <= 1'b0;
      check_valid   <= 1'b0;
      check_invalid <= 1'b0;
      if (current_state != ST_CHECK) begin
        lk_phase <= LK_IDLE;
      end else if (enter_check) begin
        dim_req  <= 1'b1;
        dim_id   <= id_a;
        lk_phase <= LK_WAIT_A;
      end else if (resp_ok && ((lk_phase == LK_WAIT_A) || (lk_phase == LK_WAIT_B))) begin
        if ((lk_phase == LK_WAIT_A) && !is_unary) begin
          a_m      <= dim_m;
          a_n      <= dim_n;
          dim_req  <= 1'b1;
          dim_id   <= id_b;
          lk_phase <= LK_WAIT_B;
        end else begin
          check_valid   <= fin_fit;
          check_invalid <= !fin_fit;
          if (fin_fit)
            {res_m, res_n} <= fin_dims;
          lk_phase <= LK_DONE;
        end
      end
    end
  end

  // Error-state countdown; an accepted retry freezes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      countdown     <= 4'd0;
      tick          <= '0;
      cd_run        <= 1'b0;
      error_timeout <= 1'b0;
    end else begin
      error_timeout <= 1'b0;
      if (current_state != ST_ERROR) begin
        cd_run <= 1'b0;
      end else if (enter_err) begin
        countdown <= 4'(ERR_SECS);
        tick      <= '0;
        cd_run    <= 1'b1;
      end else if (cd_run) begin
        if (conf_now) begin
          cd_run <= 1'b0;
        end else if (tick_wrap) begin
          tick      <= '0;
          countdown <= countdown - 4'd1;
          if (countdown == 4'd1) begin
            error_timeout <= 1'b1;
            cd_run        <= 1'b0;
          end
        end else begin
          tick <= tick + TICK_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_operand_ctrl.sv
// Directed bench for calc_operand_ctrl: operand entry, lookups, checks,
// error countdown, retry and reset behaviour.
module tb_calc_operand_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] current_state;
  logic       btn_c;
  logic [7:0] sw;
  logic       dim_req;
  logic [3:0] dim_id;
  logic       dim_valid;
  logic [2:0] dim_m, dim_n;
  logic       calc_mat_conf, check_valid, check_invalid, error_timeout;
  logic [1:0] op_type;
  logic [3:0] id_a, id_b;
  logic [2:0] res_m, res_n;
  logic [3:0] countdown;

  int tests = 0;
  int fails = 0;
  logic [31:0] all_out;
  logic seen;

  calc_operand_ctrl #(.TICK_CYCLES(4), .ERR_SECS(3)) dut (
    .clk(clk), .rst_n(rst_n), .current_state(current_state), .btn_c(btn_c), .sw(sw),
    .dim_req(dim_req), .dim_id(dim_id), .dim_valid(dim_valid), .dim_m(dim_m), .dim_n(dim_n),
    .calc_mat_conf(calc_mat_conf), .check_valid(check_valid), .check_invalid(check_invalid),
    .error_timeout(error_timeout), .op_type(op_type), .id_a(id_a), .id_b(id_b),
    .res_m(res_m), .res_n(res_n), .countdown(countdown)
  );

  always #5 clk = ~clk;

  always_comb
    all_out = {3'd0, dim_req, dim_id, calc_mat_conf, check_valid, check_invalid, error_timeout,
               op_type, id_a, id_b, res_m, res_n, countdown};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [7:0] v);
    btn_c = 1'b1;
    sw    = v;
    step();
    btn_c = 1'b0;
  endtask

  task automatic resp(input logic [2:0] m, input logic [2:0] n);
    dim_valid = 1'b1;
    dim_m     = m;
    dim_n     = n;
    step();
    dim_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; current_state = 4'd0; btn_c = 1'b0; sw = 8'd0;
    dim_valid = 1'b0; dim_m = 3'd0; dim_n = 3'd0;
    step(); step();
    chk("reset_outputs", all_out, 32'd0);
    rst_n = 1'b1;
    step();

    // add: A=1 (2x3), B=2 (2x3)
    current_state = 4'd7; press(8'h00);
    chk("add_op", op_type, 2'b00);
    current_state = 4'd8; press(8'h01);
    chk("add_a_no_conf", calc_mat_conf, 1'b0);
    chk("add_id_a", id_a, 4'd1);
    press(8'h02);
    chk("add_conf", calc_mat_conf, 1'b1);
    chk("add_id_b", id_b, 4'd2);
    step();
    chk("add_conf_single", calc_mat_conf, 1'b0);
    current_state = 4'd9; step();
    chk("add_req_a", {dim_req, dim_id}, 5'h11);
    dim_valid = 1'b1; dim_m = 3'd0; dim_n = 3'd0;
    step();
    dim_valid = 1'b0;
    chk("add_early_ignored", {dim_req, check_valid, check_invalid}, 3'b000);
    resp(3'd2, 3'd3);
    chk("add_req_b", {dim_req, dim_id}, 5'h12);
    chk("add_no_early_check", {check_valid, check_invalid}, 2'b00);
    step();
    resp(3'd2, 3'd3);
    chk("add_valid", {check_valid, check_invalid}, 2'b10);
    chk("add_res", {res_m, res_n}, {3'd2, 3'd3});
    step();
    chk("add_pulse_once", {check_valid, check_invalid, dim_req}, 3'b000);

    // matrix-multiply: 2x3 * 3x4 valid, 2x3 * 2x2 invalid
    current_state = 4'd7; press(8'h03);
    current_state = 4'd8; press(8'h01); press(8'h03);
    chk("mm_conf", calc_mat_conf, 1'b1);
    current_state = 4'd9; step();
    chk("mm_req_a", {dim_req, dim_id}, 5'h11);
    step(); resp(3'd2, 3'd3);
    chk("mm_req_b", {dim_req, dim_id}, 5'h13);
    step(); resp(3'd3, 3'd4);
    chk("mm_valid", {check_valid, check_invalid}, 2'b10);
    chk("mm_res", {res_m, res_n}, {3'd2, 3'd4});
    current_state = 4'd8; press(8'h01); press(8'h04);
    current_state = 4'd9; step(); step();
    resp(3'd2, 3'd3); step(); resp(3'd2, 3'd2);
    chk("mm_invalid", {check_valid, check_invalid}, 2'b01);
    chk("mm_res_hold", {res_m, res_n}, {3'd2, 3'd4});

    // transpose: A=5 (3x1) valid, empty A invalid
    current_state = 4'd7; press(8'h02);
    current_state = 4'd8; press(8'h05);
    chk("tr_conf_unary", calc_mat_conf, 1'b1);
    current_state = 4'd9; step();
    chk("tr_req", {dim_req, dim_id}, 5'h15);
    step(); resp(3'd3, 3'd1);
    chk("tr_valid", {check_valid, check_invalid}, 2'b10);
    chk("tr_single_req", dim_req, 1'b0);
    chk("tr_res", {res_m, res_n}, {3'd1, 3'd3});
    press(8'h09);
    chk("btn_in_check_ignored", {id_a, calc_mat_conf}, {4'd5, 1'b0});
    current_state = 4'd8; press(8'h00);
    current_state = 4'd9; step(); step();
    resp(3'd0, 3'd0);
    chk("tr_empty_invalid", {check_valid, check_invalid}, 2'b01);
    chk("tr_res_hold", {res_m, res_n}, {3'd1, 3'd3});

    // error countdown: 3 -> 0 at 4-cycle spacing, timeout 12 cycles after entry
    current_state = 4'd12; step();
    chk("cd_load", countdown, 4'd3);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("cd_cycle%0d", k), {countdown, error_timeout}, {4'(3 - k / 4), 1'(k == 12)});
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("cd_hold%0d", k), {countdown, error_timeout}, 5'd0);
    end

    // retry before timeout
    current_state = 4'd0; step();
    current_state = 4'd12; step(); step(); step();
    press(8'h05);
    chk("retry_conf", {calc_mat_conf, error_timeout}, 2'b10);
    seen = 1'b0;
    repeat (14) begin
      step();
      seen = seen | error_timeout;
    end
    chk("retry_no_timeout", seen, 1'b0);

    // retry coincident with timeout: conf wins
    current_state = 4'd0; step();
    current_state = 4'd12; step();
    repeat (11) step();
    press(8'h05);
    chk("coinc_conf_only", {calc_mat_conf, error_timeout}, 2'b10);
    seen = 1'b0;
    repeat (6) begin
      step();
      seen = seen | error_timeout;
    end
    chk("coinc_no_late_timeout", seen, 1'b0);

    // reset while waiting for a lookup response
    current_state = 4'd7; press(8'h00);
    current_state = 4'd8; press(8'h01); press(8'h02);
    current_state = 4'd9; step();
    chk("rst_pre_req", dim_req, 1'b1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_clear", all_out, 32'd0);
    current_state = 4'd0;
    step();
    rst_n = 1'b1;
    step();
    dim_valid = 1'b1; dim_m = 3'd2; dim_n = 3'd3;
    step();
    dim_valid = 1'b0;
    seen = check_valid | check_invalid | dim_req;
    repeat (3) begin
      step();
      seen = seen | check_valid | check_invalid | dim_req;
    end
    chk("rst_late_valid_ignored", seen, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
